// File: rtl/fractal_pkg.sv
// Shared types for the fractal dispatcher: fixed-point coordinate and FSM/slot encodings.
package fractal_pkg;
  localparam int INTEGER_BITS    = 8;
  localparam int FRACTIONAL_BITS = 24;
  localparam int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS;

  typedef logic signed [DATA_WIDTH-1:0] fixed_t;

  typedef enum logic [1:0] {FREE, BUSY, DONE} slot_state_e;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} disp_state_e;
endpackage

// File: rtl/fractal_dispatcher_if.sv
// Result pixel stream toward the framebuffer writer; valid/ready with per-beat x/y tag.
interface fractal_dispatcher_if #(
  parameter int PIX_WIDTH      = 11,
  parameter int MAX_ITER_WIDTH = 16
);
  logic                      valid;
  logic                      ready;
  logic [PIX_WIDTH-1:0]      x;
  logic [PIX_WIDTH-1:0]      y;
  logic [MAX_ITER_WIDTH-1:0] iter;

  modport master (output valid, x, y, iter, input ready);
  modport slave  (input valid, x, y, iter, output ready);
endinterface

// File: rtl/fractal_dispatcher_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requests starting at the pointer; pointer moves past the grant.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  // Two passes: indices at/after the pointer first, then wrap to the rest.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[k] && k >= int'(ptr_q)) begin
        found    = 1'b1;
        gnt_o[k] = en_i;
        ptr_d    = (k == N - 1) ? '0 : PW'(k + 1);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = en_i;
        ptr_d    = (k == N - 1) ? '0 : PW'(k + 1);
      end
    end
    if (!en_i) ptr_d = ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
endmodule

// File: rtl/fractal_dispatcher.sv
// Walks a WxH grid issuing Q-format c-coordinates to free cores; results leave out of order, tagged.
// Core result to pix valid: 1 cycle. Output holds while valid & !ready; finished cores wait in DONE.
module fractal_dispatcher
  import fractal_pkg::*;
#(
  parameter int INTEGER_BITS    = 8,
  parameter int FRACTIONAL_BITS = 24,
  parameter int MAX_ITER_WIDTH  = 16,
  parameter int CORE_COUNT      = 2,
  parameter int PIX_WIDTH       = 11
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   frame_start_i,
  input  logic [INTEGER_BITS+FRACTIONAL_BITS-1:0] x_start_i,
  input  logic [INTEGER_BITS+FRACTIONAL_BITS-1:0] y_start_i,
  input  logic [INTEGER_BITS+FRACTIONAL_BITS-1:0] step_i,
  input  logic [PIX_WIDTH-1:0]                   width_i,
  input  logic [PIX_WIDTH-1:0]                   height_i,
  input  logic [MAX_ITER_WIDTH-1:0]              max_iter_i,
  output logic [CORE_COUNT-1:0]                  core_rst_o,
  output logic [CORE_COUNT-1:0]                  core_start_o,
  output logic [CORE_COUNT-1:0][INTEGER_BITS+FRACTIONAL_BITS-1:0] core_x0_o,
  output logic [CORE_COUNT-1:0][INTEGER_BITS+FRACTIONAL_BITS-1:0] core_y0_o,
  output logic [MAX_ITER_WIDTH-1:0]              core_max_iter_o,
  input  logic [CORE_COUNT-1:0][MAX_ITER_WIDTH-1:0] core_iter_i,
  input  logic [CORE_COUNT-1:0]                  core_done_i,
  fractal_dispatcher_if.master                   pix,
  output logic                                   busy_o,
  output logic                                   frame_done_o
);
  localparam int DW = INTEGER_BITS + FRACTIONAL_BITS;

  disp_state_e                           st_q, st_d;
  logic [PIX_WIDTH-1:0]                  w_q, h_q, col_q, row_q;
  logic [DW-1:0]                         xs_q, step_q, xacc_q, yacc_q;
  logic [MAX_ITER_WIDTH-1:0]             miter_q;
  slot_state_e                           slot_q [CORE_COUNT];
  logic [CORE_COUNT-1:0][PIX_WIDTH-1:0]  tx_q, ty_q;
  logic [CORE_COUNT-1:0][1:0]            ign_q;
  logic [CORE_COUNT-1:0]                 start_q;
  logic [CORE_COUNT-1:0][DW-1:0]         x0_q, y0_q;
  logic                                  ov_q, fdone_q;
  logic [PIX_WIDTH-1:0]                  ox_q, oy_q;
  logic [MAX_ITER_WIDTH-1:0]             oit_q;

  logic [CORE_COUNT-1:0]     req, gnt, disp;
  logic                      all_free, load_en, disp_vld, col_last, last_pix, drain_done;
  logic [PIX_WIDTH-1:0]      cap_x, cap_y;
  logic [MAX_ITER_WIDTH-1:0] cap_it;

  always_comb begin
    req      = '0;
    all_free = 1'b1;
    for (int k = 0; k < CORE_COUNT; k++) begin
      req[k] = (slot_q[k] == DONE);
      if (slot_q[k] != FREE) all_free = 1'b0;
    end
  end

  assign load_en = !ov_q || pix.ready;

  rr_arbiter #(.N(CORE_COUNT)) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req),
    .en_i   (load_en),
    .gnt_o  (gnt)
  );

  // A slot being drained into the output register this cycle may be re-dispatched at once.
  always_comb begin
    disp     = '0;
    disp_vld = 1'b0;
    cap_x    = '0;
    cap_y    = '0;
    cap_it   = '0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      if (gnt[k]) begin
        cap_x  = tx_q[k];
        cap_y  = ty_q[k];
        cap_it = core_iter_i[k];
      end
      if (!disp_vld && st_q == RUN && (slot_q[k] == FREE || gnt[k])) begin
        disp[k]  = 1'b1;
        disp_vld = 1'b1;
      end
    end
  end

  assign col_last   = (col_q == w_q - 1'b1);
  assign last_pix   = col_last && (row_q == h_q - 1'b1);
  assign drain_done = (st_q == DRAIN) && all_free && !ov_q;

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (frame_start_i && width_i != '0 && height_i != '0) st_d = RUN;
      RUN:     if (disp_vld && last_pix) st_d = DRAIN;
      DRAIN:   if (drain_done) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q    <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      xs_q    <= '0;
      step_q  <= '0;
      xacc_q  <= '0;
      yacc_q  <= '0;
      miter_q <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      ign_q   <= '0;
      start_q <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      ov_q    <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
      oit_q   <= '0;
      fdone_q <= 1'b0;
      for (int k = 0; k < CORE_COUNT; k++) slot_q[k] <= FREE;
    end else begin
      st_q    <= st_d;
      fdone_q <= (st_q == IDLE && frame_start_i && (width_i == '0 || height_i == '0)) || drain_done;
      start_q <= disp;
      if (st_q == IDLE && frame_start_i) begin
        w_q     <= width_i;
        h_q     <= height_i;
        xs_q    <= x_start_i;
        step_q  <= step_i;
        miter_q <= max_iter_i;
        col_q   <= '0;
        row_q   <= '0;
        xacc_q  <= x_start_i;
        yacc_q  <= y_start_i;
      end
      if (disp_vld) begin
        if (col_last) begin
          col_q  <= '0;
          row_q  <= row_q + 1'b1;
          xacc_q <= xs_q;
          yacc_q <= yacc_q + step_q;
        end else begin
          col_q  <= col_q + 1'b1;
          xacc_q <= xacc_q + step_q;
        end
      end
      // ign_q masks the start cycle and the one after, when core_done_i may still be stale.
      for (int k = 0; k < CORE_COUNT; k++) begin
        if (disp[k]) begin
          slot_q[k] <= BUSY;
          tx_q[k]   <= col_q;
          ty_q[k]   <= row_q;
          x0_q[k]   <= xacc_q;
          y0_q[k]   <= yacc_q;
          ign_q[k]  <= 2'd2;
        end else if (gnt[k]) begin
          slot_q[k] <= FREE;
        end else if (slot_q[k] == BUSY) begin
          if (ign_q[k] != 2'd0)    ign_q[k]  <= ign_q[k] - 2'd1;
          else if (core_done_i[k]) slot_q[k] <= DONE;
        end
      end
      if (|gnt) begin
        ov_q  <= 1'b1;
        ox_q  <= cap_x;
        oy_q  <= cap_y;
        oit_q <= cap_it;
      end else if (pix.ready) begin
        ov_q  <= 1'b0;
      end
    end
  end

  assign core_rst_o      = {CORE_COUNT{st_q == IDLE}};
  assign core_start_o    = start_q;
  assign core_x0_o       = x0_q;
  assign core_y0_o       = y0_q;
  assign core_max_iter_o = miter_q;
  assign pix.valid       = ov_q;
  assign pix.x           = ox_q;
  assign pix.y           = oy_q;
  assign pix.iter        = oit_q;
  assign busy_o          = (st_q == RUN) || (st_q == DRAIN);
  assign frame_done_o    = fdone_q;
endmodule

// File: tb/tb_fractal_dispatcher.sv
// Directed bench: a 1-core instance for the coordinate walk, a 4-core instance with stub cores and a scoreboard.
module tb_fractal_dispatcher;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] itf(logic [31:0] x0, logic [31:0] y0);
    return {x0[27:20], y0[27:20]};
  endfunction

  logic [31:0] xs, ys, stp;
  logic [10:0] w, h;
  logic [15:0] mi;
  logic        a_fs, b_fs;

  // ---------------- 1-core instance ----------------
  logic [0:0]       a_crst, a_cstart, a_cdone;
  logic [0:0][31:0] a_x0, a_y0;
  logic [0:0][15:0] a_iter;
  logic [15:0]      a_mi;
  logic             a_busy, a_fd;
  fractal_dispatcher_if #(.PIX_WIDTH(11), .MAX_ITER_WIDTH(16)) a_if();

  fractal_dispatcher #(.CORE_COUNT(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .frame_start_i(a_fs),
    .x_start_i(xs), .y_start_i(ys), .step_i(stp), .width_i(w), .height_i(h), .max_iter_i(mi),
    .core_rst_o(a_crst), .core_start_o(a_cstart), .core_x0_o(a_x0), .core_y0_o(a_y0),
    .core_max_iter_o(a_mi), .core_iter_i(a_iter), .core_done_i(a_cdone),
    .pix(a_if), .busy_o(a_busy), .frame_done_o(a_fd)
  );

  int a_cnt = 0;
  always @(posedge clk) begin
    if (a_crst[0]) begin
      a_cdone[0] <= 1'b0; a_cnt <= 0;
    end else if (a_cstart[0]) begin
      a_cdone[0] <= 1'b0; a_cnt <= 2; a_iter[0] <= itf(a_x0[0], a_y0[0]);
    end else if (a_cnt > 0) begin
      a_cnt <= a_cnt - 1;
      if (a_cnt == 1) a_cdone[0] <= 1'b1;
    end
  end

  logic [31:0] ax_q[$], ay_q[$];
  int a_beats = 0, a_fdn = 0;
  always @(negedge clk) begin
    if (a_cstart[0]) begin ax_q.push_back(a_x0[0]); ay_q.push_back(a_y0[0]); end
    if (a_if.valid && a_if.ready) a_beats++;
    if (a_fd) a_fdn++;
  end

  // ---------------- 4-core instance ----------------
  logic [3:0]       b_crst, b_cstart, b_cdone;
  logic [3:0][31:0] b_x0, b_y0;
  logic [3:0][15:0] b_iter;
  logic [15:0]      b_mi;
  logic             b_busy, b_fd;
  fractal_dispatcher_if #(.PIX_WIDTH(11), .MAX_ITER_WIDTH(16)) b_if();

  fractal_dispatcher #(.CORE_COUNT(4)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .frame_start_i(b_fs),
    .x_start_i(xs), .y_start_i(ys), .step_i(stp), .width_i(w), .height_i(h), .max_iter_i(mi),
    .core_rst_o(b_crst), .core_start_o(b_cstart), .core_x0_o(b_x0), .core_y0_o(b_y0),
    .core_max_iter_o(b_mi), .core_iter_i(b_iter), .core_done_i(b_cdone),
    .pix(b_if), .busy_o(b_busy), .frame_done_o(b_fd)
  );

  int b_lat[4];
  int b_cnt[4];
  bit lat_rand = 1'b0;
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (b_crst[k]) begin
        b_cdone[k] <= 1'b0; b_cnt[k] <= 0;
      end else if (b_cstart[k]) begin
        b_cdone[k] <= 1'b0;
        b_cnt[k]   <= lat_rand ? int'($urandom_range(1, 12)) : b_lat[k];
        b_iter[k]  <= itf(b_x0[k], b_y0[k]);
      end else if (b_cnt[k] > 0) begin
        b_cnt[k] <= b_cnt[k] - 1;
        if (b_cnt[k] == 1) b_cdone[k] <= 1'b1;
      end
    end
  end

  int rdy_mode = 1;
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       b_if.ready = 1'b0;
      1:       b_if.ready = 1'b1;
      default: b_if.ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  typedef struct {logic [31:0] x0; logic [31:0] y0;} exp_t;
  exp_t        dq[$];
  bit          seen[int];
  int          order_q[$];
  int          b_beats = 0, b_fdn = 0, b_starts = 0;
  logic [31:0] cur_xs, cur_ys, cur_step;
  bit          prev_stall = 1'b0;
  logic [37:0] prev_beat;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (b_cstart[k]) begin
        b_starts++;
        if (dq.size() == 0) chk("unexpected_start", 1, 0);
        else begin
          exp_t e;
          e = dq.pop_front();
          chk("core_x0", b_x0[k], e.x0);
          chk("core_y0", b_y0[k], e.y0);
        end
      end
    end
    if (!rst_n) prev_stall = 1'b0;
    if (prev_stall) chk("hold_while_stalled", {b_if.valid, b_if.x, b_if.y, b_if.iter}, {1'b1, prev_beat});
    if (b_if.valid && b_if.ready) begin
      int key;
      key = int'(b_if.y) * 4096 + int'(b_if.x);
      chk("duplicate_pixel", seen.exists(key), 0);
      chk("tag_iter", b_if.iter, itf(cur_xs + 32'(b_if.x) * cur_step, cur_ys + 32'(b_if.y) * cur_step));
      seen[key] = 1'b1;
      b_beats++;
      order_q.push_back(int'(b_if.x));
    end
    prev_stall = rst_n && b_if.valid && !b_if.ready;
    prev_beat  = {b_if.x, b_if.y, b_if.iter};
    if (b_fd) b_fdn++;
  end

  task automatic start_b(int wi, int hi);
    cur_xs = xs; cur_ys = ys; cur_step = stp;
    dq.delete(); seen.delete(); order_q.delete(); b_beats = 0;
    for (int r = 0; r < hi; r++)
      for (int c = 0; c < wi; c++) begin
        exp_t e;
        e.x0 = xs + 32'(c) * stp;
        e.y0 = ys + 32'(r) * stp;
        dq.push_back(e);
      end
    @(negedge clk);
    w = 11'(wi); h = 11'(hi); b_fs = 1'b1;
    @(negedge clk);
    b_fs = 1'b0;
  endtask

  task automatic wait_fd_b(int budget, int npix);
    int f0, n;
    f0 = b_fdn; n = 0;
    while (b_fdn == f0 && n < budget) begin @(negedge clk); n++; end
    chk("frame_done_count", b_fdn, f0 + 1);
    chk("beats", b_beats, npix);
    chk("unique_pixels", seen.size(), npix);
    chk("all_dispatched", dq.size(), 0);
    chk("idle_after_frame", b_busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, f0, n;
    rst_n = 1'b0; a_fs = 1'b0; b_fs = 1'b0; a_if.ready = 1'b1;
    xs = 32'hFE00_0000; ys = 32'hFF00_0000; stp = 32'h0080_0000;
    w = '0; h = '0; mi = 16'd500;
    b_lat = '{5, 5, 5, 5};
    #12;
    chk("rst_core_rst_b", b_crst, 4'hF);
    chk("rst_core_rst_a", a_crst, 1'b1);
    chk("rst_start_b", b_cstart, 4'h0);
    chk("rst_valid_b", b_if.valid, 0);
    chk("rst_busy_b", b_busy, 0);
    chk("rst_done_b", b_fd, 0);
    chk("rst_x0_b_zero", (b_x0 == '0), 1);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1 core, 2x2 raster walk
    w = 11'd2; h = 11'd2; a_fs = 1'b1;
    @(negedge clk); a_fs = 1'b0;
    n = 0;
    while (a_fdn == 0 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("a_frame_done_once", a_fdn, 1);
    chk("a_beats", a_beats, 4);
    chk("a_starts", ax_q.size(), 4);
    chk("a_x0_0", ax_q[0], 32'hFE00_0000); chk("a_y0_0", ay_q[0], 32'hFF00_0000);
    chk("a_x0_1", ax_q[1], 32'hFE80_0000); chk("a_y0_1", ay_q[1], 32'hFF00_0000);
    chk("a_x0_2", ax_q[2], 32'hFE00_0000); chk("a_y0_2", ay_q[2], 32'hFF80_0000);
    chk("a_x0_3", ax_q[3], 32'hFE80_0000); chk("a_y0_3", ay_q[3], 32'hFF80_0000);

    // 4 cores, latencies staggered so completion order is 3,1,2,0 despite one-per-cycle dispatch
    b_lat = '{12, 5, 7, 1};
    start_b(4, 1);
    chk("max_iter_forwarded", b_mi, 16'd500);
    wait_fd_b(300, 4);
    chk("order0", order_q[0], 3); chk("order1", order_q[1], 1);
    chk("order2", order_q[2], 2); chk("order3", order_q[3], 0);

    // empty frame
    s0 = b_starts; f0 = b_fdn;
    @(negedge clk); w = '0; h = 11'd5; b_fs = 1'b1;
    @(negedge clk); b_fs = 1'b0;
    chk("empty_done_pulse", b_fd, 1);
    chk("empty_not_busy", b_busy, 0);
    repeat (6) @(negedge clk);
    chk("empty_no_start", b_starts, s0);
    chk("empty_done_once", b_fdn, f0 + 1);

    // downstream stall for 20 cycles mid-frame
    b_lat = '{3, 3, 3, 3};
    start_b(16, 1);
    repeat (6) @(negedge clk);
    rdy_mode = 0;
    repeat (10) @(negedge clk);
    s0 = b_starts;
    repeat (10) @(negedge clk);
    chk("stall_no_dispatch", b_starts, s0);
    chk("stall_valid_held", b_if.valid, 1);
    rdy_mode = 1;
    wait_fd_b(400, 16);

    // reset in RUN with two cores busy
    b_lat = '{30, 30, 30, 30};
    start_b(8, 1);
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", b_busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", b_busy, 0);
    chk("mid_rst_core_rst", b_crst, 4'hF);
    chk("mid_rst_start", b_cstart, 4'h0);
    chk("mid_rst_valid", b_if.valid, 0);
    chk("mid_rst_x0_zero", (b_x0 == '0), 1);
    chk("mid_rst_done", b_fd, 0);
    f0 = b_fdn;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_partial_done", b_fdn, f0);
    b_lat = '{2, 4, 6, 8};
    start_b(3, 2);
    wait_fd_b(300, 6);

    // full 64x48 frame, random latencies and random ready
    xs = 32'hFE00_0000; ys = 32'hFE80_0000; stp = 32'h0010_0000;
    lat_rand = 1'b1; rdy_mode = 2;
    start_b(64, 48);
    wait_fd_b(60000, 64 * 48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
